// File: rtl/alu_instr_sequencer_if.sv
// Control bus between the ALU instruction sequencer and the datapath.
// master = sequencer side, slave = datapath / bench side.
interface alu_instr_sequencer_if #(
   parameter int DATA_W    = 32,
   parameter int OPC_W     = 5,
   parameter int REG_SEL_W = 4
);
   localparam int NUM_REGS = 2**REG_SEL_W;

   // Handshake: start is a level request, sampled only in IDLE and in the
   // final state of an instruction; mem_ready marks Mdatain valid and is
   // only looked at while waiting in T1. Both are ignored everywhere else.
   logic                start;
   logic                mem_ready;
   logic [DATA_W-1:0]   IR;
   logic [NUM_REGS-1:0] Rin;
   logic [NUM_REGS-1:0] Rout;
   logic                PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin;
   logic                Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
   logic [OPC_W-1:0]    opcode;
   logic                busy, done, illegal, mem_timeout;
   logic [2:0]          state_dbg;

   modport master (
      input  start, mem_ready, IR,
      output Rin, Rout, PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
             Read, MDRin, MDRout, IRin, Yin, HIin, LOin, opcode,
             busy, done, illegal, mem_timeout, state_dbg
   );

   modport slave (
      output start, mem_ready, IR,
      input  Rin, Rout, PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
             Read, MDRin, MDRout, IRin, Yin, HIin, LOin, opcode,
             busy, done, illegal, mem_timeout, state_dbg
   );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Fetch / decode / execute sequencer for three-register ALU and MUL/DIV
// instructions; drives one-hot register strobes and datapath controls.
module alu_instr_sequencer #(
   parameter int             DATA_W      = 32,
   parameter int             OPC_W       = 5,
   parameter int             REG_SEL_W   = 4,
   parameter logic [OPC_W-1:0] ALU_OP_LO = 5'b00011,
   parameter logic [OPC_W-1:0] ALU_OP_HI = 5'b01001,
   parameter logic [OPC_W-1:0] MUL_OP    = 5'b01111,
   parameter logic [OPC_W-1:0] DIV_OP    = 5'b10000,
   parameter int             MEM_TIMEOUT = 15
) (
   input logic Clock,
   input logic clear,
   alu_instr_sequencer_if.master bus
);
   localparam int NUM_REGS = 2**REG_SEL_W;
   localparam int CNT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam int LOW_W    = DATA_W - OPC_W - 3*REG_SEL_W;

   typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     wait_cnt;
   logic [OPC_W-1:0]     op;
   logic [REG_SEL_W-1:0] ra, rb, rc;
   logic                 is_alu, is_md, legal, first_t1, timeout_hit;
   logic                 unused_ir;

   assign op = bus.IR[DATA_W-1 -: OPC_W];
   assign ra = bus.IR[DATA_W-OPC_W-1 -: REG_SEL_W];
   assign rb = bus.IR[DATA_W-OPC_W-REG_SEL_W-1 -: REG_SEL_W];
   assign rc = bus.IR[DATA_W-OPC_W-2*REG_SEL_W-1 -: REG_SEL_W];
   assign unused_ir = ^bus.IR[LOW_W-1:0];

   assign is_alu = (op >= ALU_OP_LO) && (op <= ALU_OP_HI);
   assign is_md  = (op == MUL_OP) || (op == DIV_OP);
   assign legal  = is_alu || is_md;

   // Staying in T1 implies a not-ready cycle was counted, so a zero count
   // identifies the first T1 cycle without a separate flag.
   assign first_t1    = (wait_cnt == '0);
   assign timeout_hit = !bus.mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

   assign bus.state_dbg = state;

   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == T0)
            wait_cnt <= '0;
         else if (state == T1 && !bus.mem_ready)
            wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.start) state_nxt = T0;
         T0:   state_nxt = T1;
         T1: begin
            if (bus.mem_ready)  state_nxt = T2;
            else if (timeout_hit) state_nxt = IDLE;
         end
         T2:   state_nxt = T3;
         T3:   state_nxt = legal ? T4 : IDLE;
         T4:   state_nxt = T5;
         T5: begin
            if (is_md)          state_nxt = T6;
            else                state_nxt = bus.start ? T0 : IDLE;
         end
         T6:   state_nxt = bus.start ? T0 : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.Rin = '0;      bus.Rout = '0;
      bus.PCout = 1'b0;  bus.MARin = 1'b0;    bus.IncPC = 1'b0; bus.Zin = 1'b0;
      bus.Zlowout = 1'b0; bus.Zhighout = 1'b0; bus.PCin = 1'b0;  bus.Read = 1'b0;
      bus.MDRin = 1'b0;  bus.MDRout = 1'b0;   bus.IRin = 1'b0;  bus.Yin = 1'b0;
      bus.HIin = 1'b0;   bus.LOin = 1'b0;     bus.opcode = '0;
      bus.busy = (state != IDLE);
      bus.done = 1'b0;   bus.illegal = 1'b0;  bus.mem_timeout = 1'b0;
      case (state)
         T0: begin
            bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
         end
         T1: begin
            bus.Zlowout     = first_t1;
            bus.PCin        = first_t1;
            bus.Read        = 1'b1;
            bus.MDRin       = 1'b1;
            bus.mem_timeout = timeout_hit;
         end
         T2: begin
            bus.MDRout = 1'b1; bus.IRin = 1'b1;
         end
         T3: begin
            if (legal) begin
               bus.Rout = NUM_REGS'(1) << rb;
               bus.Yin  = 1'b1;
            end else begin
               bus.illegal = 1'b1;
            end
         end
         T4: begin
            bus.Rout   = NUM_REGS'(1) << rc;
            bus.opcode = op;
            bus.Zin    = 1'b1;
         end
         T5: begin
            bus.Zlowout = 1'b1;
            if (is_md) begin
               bus.LOin = 1'b1;
            end else begin
               bus.Rin  = NUM_REGS'(1) << ra;
               bus.done = 1'b1;
            end
         end
         T6: begin
            bus.Zhighout = 1'b1; bus.HIin = 1'b1; bus.done = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Randomized bench: a per-instruction cycle model expands each instruction
// into its expected control vectors, compared cycle by cycle with the DUT.
module tb_alu_instr_sequencer;
   localparam int MEM_TIMEOUT = 15;
   localparam int CTL_W       = 55;

   typedef struct packed {
      logic [15:0] rin;
      logic [15:0] rout;
      logic pcout, marin, incpc, zin, zlowout, zhighout, pcin;
      logic read, mdrin, mdrout, irin, yin, hiin, loin;
      logic [4:0] opcode;
      logic busy, done, illegal, mem_timeout;
   } ctl_t;

   logic Clock = 1'b0;
   logic clear;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   logic [CTL_W-1:0] exp_q[$];
   bit               st_q[$];
   bit               rdy_q[$];
   logic [31:0]      ir_q[$];

   alu_instr_sequencer_if bus ();

   alu_instr_sequencer dut (
      .Clock (Clock),
      .clear (clear),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic ctl_t sample();
      ctl_t c;
      c.rin = bus.Rin;         c.rout = bus.Rout;
      c.pcout = bus.PCout;     c.marin = bus.MARin;     c.incpc = bus.IncPC;
      c.zin = bus.Zin;         c.zlowout = bus.Zlowout; c.zhighout = bus.Zhighout;
      c.pcin = bus.PCin;       c.read = bus.Read;       c.mdrin = bus.MDRin;
      c.mdrout = bus.MDRout;   c.irin = bus.IRin;       c.yin = bus.Yin;
      c.hiin = bus.HIin;       c.loin = bus.LOin;       c.opcode = bus.opcode;
      c.busy = bus.busy;       c.done = bus.done;       c.illegal = bus.illegal;
      c.mem_timeout = bus.mem_timeout;
      return c;
   endfunction

   task automatic push(input ctl_t c, input bit s, input bit r, input logic [31:0] ir);
      exp_q.push_back(c);
      st_q.push_back(s);
      rdy_q.push_back(r);
      ir_q.push_back(ir);
   endtask

   task automatic push_idle(input bit s);
      ctl_t c;
      c = '0;
      push(c, s, 1'($urandom_range(0, 1)), $urandom);
   endtask

   // Expected cycles of one instruction, starting at its T0 cycle.
   task automatic model_instr(input logic [31:0] ir, input int nr, input bit chain,
                              output bit ended_final);
      ctl_t       c;
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      bit         md, alu;
      op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
      alu = (op >= 5'd3) && (op <= 5'd9);
      md  = (op == 5'd15) || (op == 5'd16);
      ended_final = 1'b0;

      c = '0; c.busy = 1; c.pcout = 1; c.marin = 1; c.incpc = 1; c.zin = 1;
      push(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ir);

      if (nr >= MEM_TIMEOUT) begin
         for (int i = 0; i < MEM_TIMEOUT; i++) begin
            c = '0; c.busy = 1; c.read = 1; c.mdrin = 1;
            c.zlowout = (i == 0); c.pcin = (i == 0);
            c.mem_timeout = (i == MEM_TIMEOUT - 1);
            push(c, 1'($urandom_range(0, 1)), 1'b0, ir);
         end
         return;
      end
      for (int i = 0; i <= nr; i++) begin
         c = '0; c.busy = 1; c.read = 1; c.mdrin = 1;
         c.zlowout = (i == 0); c.pcin = (i == 0);
         push(c, 1'($urandom_range(0, 1)), (i == nr), ir);
      end

      c = '0; c.busy = 1; c.mdrout = 1; c.irin = 1;
      push(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ir);

      c = '0; c.busy = 1;
      if (!(alu || md)) begin
         c.illegal = 1;
         push(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ir);
         return;
      end
      c.rout = 16'd1 << rb; c.yin = 1;
      push(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ir);

      c = '0; c.busy = 1; c.rout = 16'd1 << rc; c.opcode = op; c.zin = 1;
      push(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ir);

      c = '0; c.busy = 1; c.zlowout = 1;
      if (md) begin
         c.loin = 1;
         push(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ir);
         c = '0; c.busy = 1; c.zhighout = 1; c.hiin = 1; c.done = 1;
         push(c, chain, 1'($urandom_range(0, 1)), ir);
      end else begin
         c.rin = 16'd1 << ra; c.done = 1;
         push(c, chain, 1'($urandom_range(0, 1)), ir);
      end
      ended_final = 1'b1;
   endtask

   // chained=1 means the DUT will enter T0 directly from the previous final state.
   task automatic add_instr(input logic [31:0] ir, input int nr, input bit chain,
                            inout bit chained);
      bit ef;
      if (!chained) begin
         repeat ($urandom_range(0, 2)) push_idle(1'b0);
         push_idle(1'b1);
      end
      model_instr(ir, nr, chain, ef);
      chained = chain && ef;
   endtask

   task automatic run_queue();
      while (exp_q.size() > 0) begin
         @(negedge Clock);
         bus.start     = st_q.pop_front();
         bus.mem_ready = rdy_q.pop_front();
         bus.IR        = ir_q.pop_front();
         #1;
         check($sformatf("ctl_cyc%0d", cyc), 64'(sample()), 64'(exp_q.pop_front()));
         cyc++;
      end
   endtask

   initial begin
      bit          chained;
      bit          found;
      logic [31:0] ir;
      logic [4:0]  op;
      int          nr, sel;

      clear = 1'b1;
      bus.start = 1'b0; bus.mem_ready = 1'b0; bus.IR = '0;
      repeat (2) @(negedge Clock);
      #1;
      check("reset_outputs", 64'(sample()), 64'd0);
      @(negedge Clock);
      clear = 1'b0;

      // Abort mid-T4 with an asynchronous clear.
      bus.IR = 32'h28918000; bus.mem_ready = 1'b1; bus.start = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge Clock);
         bus.start = 1'b0;
         #1;
         if (bus.opcode == 5'b00101) found = 1'b1;
      end
      check("reach_t4", 64'(found), 64'd1);
      clear = 1'b1;
      #1;
      check("clear_async", 64'(sample()), 64'd0);
      check("clear_busy", 64'(bus.busy), 64'd0);
      @(negedge Clock);
      #1;
      check("clear_held", 64'(sample()), 64'd0);
      clear = 1'b0;

      chained = 1'b0;
      add_instr(32'h28918000, 0, 1'b0, chained);
      add_instr(32'h28918000, 3, 1'b0, chained);
      add_instr({5'b01111, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 1'b0, chained);
      add_instr({5'b10000, 4'd4, 4'd5, 4'd6, 15'h1234}, 1, 1'b0, chained);
      add_instr({5'b11111, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 1'b0, chained);
      add_instr({5'b00010, 4'd7, 4'd8, 4'd9, 15'd0}, 0, 1'b0, chained);
      add_instr({5'b01010, 4'd7, 4'd8, 4'd9, 15'd0}, 0, 1'b0, chained);
      add_instr(32'h28918000, MEM_TIMEOUT, 1'b0, chained);
      add_instr(32'h28918000, 0, 1'b1, chained);
      add_instr({5'b00011, 4'd15, 4'd0, 4'd14, 15'd0}, 0, 1'b0, chained);
      add_instr({5'b01001, 4'd0, 4'd15, 4'd1, 15'd0}, 2, 1'b1, chained);
      add_instr({5'b01111, 4'd3, 4'd4, 4'd5, 15'd0}, 0, 1'b0, chained);

      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 5);
         if (sel <= 2)      op = 5'($urandom_range(3, 9));
         else if (sel == 3) op = 5'b01111;
         else if (sel == 4) op = 5'b10000;
         else               op = 5'($urandom_range(0, 31));
         ir = {op, 27'($urandom)};
         sel = $urandom_range(0, 9);
         if (sel < 6)       nr = 0;
         else if (sel < 9)  nr = $urandom_range(1, 4);
         else               nr = MEM_TIMEOUT + $urandom_range(0, 3);
         add_instr(ir, nr, (n != 39) && ($urandom_range(0, 1) == 1), chained);
      end
      push_idle(1'b0);
      push_idle(1'b0);

      run_queue();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
